// File: rtl/sid_sd_dac.sv
// Second-order delta-sigma DAC for the two 12-bit SID/PSG streams, with routing, shift attenuation and a soft mute ramp.
// The output changes only on a modulator tick; a captured sample reaches pdm_out within 2 ticks.
module sid_sd_dac #(
  parameter int DIV = 4,
  parameter int IW  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in_1,
  input  logic [11:0] sample_in_2,
  input  logic        sample_ready,
  input  logic        en,
  input  logic [1:0]  mix_mode,
  input  logic [2:0]  atten,
  input  logic        mute,
  input  logic        overrun_clr,
  output logic        pdm_out_1,
  output logic        pdm_out_2,
  output logic        overrun,
  output logic        ramp_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = IW + 2;
  localparam logic [CW-1:0]        CTR_MAX = CW'(DIV - 1);
  localparam logic signed [AW-1:0] SAT_HI  = AW'((2 ** (IW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO  = -SAT_HI;
  localparam logic signed [AW-1:0] FB      = AW'(2048);
  localparam logic signed [11:0]   CLIP    = 12'sd1536;

  logic [CW-1:0]        div_ctr;
  logic                 tick;
  logic [11:0]          pending_1, pending_2, active_1, active_2;
  logic                 pending_valid;
  logic [8:0]           ramp, ramp_nxt;
  logic signed [IW-1:0] i1_1, i2_1, i1_2, i2_2;
  logic signed [IW-1:0] i1_1n, i2_1n, i1_2n, i2_2n;
  logic signed [11:0]   x1, x2, avg, m1, m2, a1, a2, sr1, sr2, s1, s2;
  logic signed [12:0]   sum13;
  logic signed [21:0]   p1, p2;
  logic signed [AW-1:0] fb1, fb2;

  function automatic logic signed [IW-1:0] sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] c;
    c = (v > SAT_HI) ? SAT_HI : (v < SAT_LO) ? SAT_LO : v;
    return IW'(c);
  endfunction

  function automatic logic signed [AW-1:0] ext(input logic signed [IW-1:0] v);
    return $signed({{2{v[IW-1]}}, v});
  endfunction

  function automatic logic signed [AW-1:0] ext12(input logic signed [11:0] v);
    return $signed({{(AW-12){v[11]}}, v});
  endfunction

  assign tick = en && (div_ctr == CTR_MAX);

  // Offset binary to two's complement is just an MSB flip.
  assign x1    = $signed({~active_1[11], active_1[10:0]});
  assign x2    = $signed({~active_2[11], active_2[10:0]});
  assign sum13 = $signed({x1[11], x1}) + $signed({x2[11], x2});
  assign avg   = 12'(sum13 >>> 1);

  always_comb begin
    m1 = x1;
    m2 = x2;
    case (mix_mode)
      2'd1: begin m1 = avg; m2 = avg; end
      2'd2: begin m1 = x2;  m2 = x1;  end
      2'd3: begin m2 = x1; end
      default: ;
    endcase
  end

  assign a1  = m1 >>> atten;
  assign a2  = m2 >>> atten;
  assign p1  = $signed({{10{a1[11]}}, a1}) * $signed({13'd0, ramp});
  assign p2  = $signed({{10{a2[11]}}, a2}) * $signed({13'd0, ramp});
  assign sr1 = 12'(p1 >>> 8);
  assign sr2 = 12'(p2 >>> 8);
  // Keep the modulator input inside its stable range (12.5%..87.5% density).
  assign s1  = (sr1 > CLIP) ? CLIP : (sr1 < -CLIP) ? -CLIP : sr1;
  assign s2  = (sr2 > CLIP) ? CLIP : (sr2 < -CLIP) ? -CLIP : sr2;

  always_comb begin
    fb1   = pdm_out_1 ? FB : -FB;
    fb2   = pdm_out_2 ? FB : -FB;
    i1_1n = sat(ext(i1_1) + ext12(s1) - fb1);
    i2_1n = sat(ext(i2_1) + ext(i1_1n) - fb1);
    i1_2n = sat(ext(i1_2) + ext12(s2) - fb2);
    i2_2n = sat(ext(i2_2) + ext(i1_2n) - fb2);
  end

  always_comb begin
    ramp_nxt = ramp;
    if (tick) begin
      if (!mute && ramp != 9'd256)    ramp_nxt = ramp + 9'd1;
      else if (mute && ramp != 9'd0)  ramp_nxt = ramp - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ctr       <= '0;
      pending_1     <= 12'h800;
      pending_2     <= 12'h800;
      active_1      <= 12'h800;
      active_2      <= 12'h800;
      pending_valid <= 1'b0;
      ramp          <= 9'd0;
      ramp_done     <= 1'b0;
      overrun       <= 1'b0;
      i1_1 <= '0; i2_1 <= '0; i1_2 <= '0; i2_2 <= '0;
      pdm_out_1     <= 1'b0;
      pdm_out_2     <= 1'b0;
    end else begin
      if (!en || tick) div_ctr <= '0;
      else             div_ctr <= div_ctr + CW'(1);

      // A tick drains the old pending sample before a same-cycle capture refills it.
      if (tick && pending_valid) begin
        active_1 <= pending_1;
        active_2 <= pending_2;
      end
      if (sample_ready) begin
        pending_1     <= sample_in_1;
        pending_2     <= sample_in_2;
        pending_valid <= 1'b1;
      end else if (tick) begin
        pending_valid <= 1'b0;
      end

      if (overrun_clr)                                 overrun <= 1'b0;
      else if (sample_ready && pending_valid && !tick) overrun <= 1'b1;

      ramp      <= ramp_nxt;
      ramp_done <= mute ? (ramp_nxt == 9'd0) : (ramp_nxt == 9'd256);

      if (!en) begin
        i1_1 <= '0; i2_1 <= '0; i1_2 <= '0; i2_2 <= '0;
        pdm_out_1 <= 1'b0;
        pdm_out_2 <= 1'b0;
      end else if (tick) begin
        i1_1 <= i1_1n; i2_1 <= i2_1n;
        i1_2 <= i1_2n; i2_2 <= i2_2n;
        pdm_out_1 <= ~i2_1n[IW-1];
        pdm_out_2 <= ~i2_2n[IW-1];
      end
    end
  end

endmodule

// File: tb/tb_sid_sd_dac.sv
// Bench for sid_sd_dac: table of routing/attenuation vectors scored on PDM ones density, plus timing corner cases.
module tb_sid_sd_dac;
  localparam int DIV = 4;
  localparam int N   = 1024;
  localparam int TOL = 10;

  logic        clk = 1'b0;
  logic        rst_n, sample_ready, en, mute, overrun_clr;
  logic [11:0] sample_in_1, sample_in_2;
  logic [1:0]  mix_mode;
  logic [2:0]  atten;
  logic        pdm_out_1, pdm_out_2, overrun, ramp_done;
  logic        d1_pdm_1, d1_pdm_2, d1_overrun, d1_ramp_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  att;
    logic [11:0] s1;
    logic [11:0] s2;
    int          e1;
    int          e2;
  } vec_t;

  typedef struct {
    int idx;
    int e1;
    int e2;
  } exp_t;

  vec_t tbl[9];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sid_sd_dac #(.DIV(DIV), .IW(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in_1(sample_in_1), .sample_in_2(sample_in_2),
    .sample_ready(sample_ready), .en(en), .mix_mode(mix_mode), .atten(atten),
    .mute(mute), .overrun_clr(overrun_clr), .pdm_out_1(pdm_out_1), .pdm_out_2(pdm_out_2),
    .overrun(overrun), .ramp_done(ramp_done)
  );

  sid_sd_dac #(.DIV(1), .IW(16)) dut_div1 (
    .clk(clk), .rst_n(rst_n), .sample_in_1(sample_in_1), .sample_in_2(sample_in_2),
    .sample_ready(sample_ready), .en(en), .mix_mode(mix_mode), .atten(atten),
    .mute(mute), .overrun_clr(overrun_clr), .pdm_out_1(d1_pdm_1), .pdm_out_2(d1_pdm_2),
    .overrun(d1_overrun), .ramp_done(d1_ramp_done)
  );

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // One sample per tick period; pdm holds between ticks so any phase works.
  task automatic measure(input int ticks, output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    for (int t = 0; t < ticks; t++) begin
      repeat (DIV) @(negedge clk);
      c1 += int'(pdm_out_1);
      c2 += int'(pdm_out_2);
    end
  endtask

  task automatic pulse_sample(input logic [11:0] a, input logic [11:0] b);
    sample_in_1  = a;
    sample_in_2  = b;
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  initial begin
    int   c1, c2, w;
    exp_t e;

    // Expected counts are ones out of 1024 ticks: 512 + s/4 with s = clamp(m >>> atten).
    tbl[0] = '{2'd0, 3'd0, 12'h800, 12'h800, 512, 512};
    tbl[1] = '{2'd0, 3'd0, 12'hFFF, 12'hFFF, 896, 896};
    tbl[2] = '{2'd0, 3'd2, 12'hFFF, 12'hFFF, 640, 640};
    tbl[3] = '{2'd1, 3'd0, 12'hC00, 12'h400, 512, 512};
    tbl[4] = '{2'd0, 3'd0, 12'hC00, 12'h800, 768, 512};
    tbl[5] = '{2'd2, 3'd0, 12'hC00, 12'h800, 512, 768};
    tbl[6] = '{2'd3, 3'd0, 12'h400, 12'hC00, 256, 256};
    tbl[7] = '{2'd0, 3'd0, 12'h000, 12'h900, 128, 576};
    tbl[8] = '{2'd1, 3'd1, 12'hFFF, 12'h900, 656, 656};

    rst_n = 1'b0; en = 1'b1; mute = 1'b0; overrun_clr = 1'b0; sample_ready = 1'b0;
    mix_mode = 2'd0; atten = 3'd0; sample_in_1 = 12'h800; sample_in_2 = 12'h800;
    #3;
    check("reset_pdm1", pdm_out_1, 0, 0);
    check("reset_pdm2", pdm_out_2, 0, 0);
    check("reset_overrun", overrun, 0, 0);
    check("reset_ramp_done", ramp_done, 0, 0);

    @(negedge clk) rst_n = 1'b1;
    repeat (1023) @(negedge clk);
    check("ramp_done_before_256_ticks", ramp_done, 0, 0);
    @(negedge clk);
    check("ramp_done_at_256_ticks", ramp_done, 1, 0);

    for (int i = 0; i < 9; i++) begin
      mix_mode = tbl[i].mode;
      atten    = tbl[i].att;
      pulse_sample(tbl[i].s1, tbl[i].s2);
      exp_q.push_back('{i, tbl[i].e1, tbl[i].e2});
      repeat (128 * DIV) @(negedge clk);
      measure(N, c1, c2);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_density_ch1", e.idx), c1, e.e1, TOL);
      check($sformatf("vec%0d_density_ch2", e.idx), c2, e.e2, TOL);
    end

    // Mute ramp down at full scale input, then back up.
    mix_mode = 2'd0;
    atten    = 3'd0;
    pulse_sample(12'hFFF, 12'hFFF);
    check("ramp_done_before_mute", ramp_done, 1, 0);
    mute = 1'b1;
    exp_q.push_back('{100, 512, 512});
    @(negedge clk);
    check("ramp_done_falls_on_mute", ramp_done, 0, 0);
    repeat (250 * DIV) @(negedge clk);
    check("ramp_done_mid_ramp_down", ramp_done, 0, 0);
    repeat (12 * DIV) @(negedge clk);
    check("ramp_done_muted", ramp_done, 1, 0);
    measure(N, c1, c2);
    e = exp_q.pop_front();
    check("muted_density_ch1", c1, e.e1, TOL);
    check("muted_density_ch2", c2, e.e2, TOL);
    mute = 1'b0;
    @(negedge clk);
    check("ramp_done_falls_on_unmute", ramp_done, 0, 0);
    repeat (262 * DIV) @(negedge clk);
    check("ramp_done_unmuted", ramp_done, 1, 0);

    // Disable for 10 clocks, then time the first tick after re-enable.
    en = 1'b0;
    @(negedge clk);
    check("en0_pdm1", pdm_out_1, 0, 0);
    check("en0_pdm2", pdm_out_2, 0, 0);
    repeat (9) @(negedge clk);
    check("en0_pdm1_after_10", pdm_out_1, 0, 0);
    check("en0_div1_pdm1", d1_pdm_1, 0, 0);
    en = 1'b1;
    @(negedge clk);
    check("div1_first_tick_pdm1", d1_pdm_1, 1, 0);
    repeat (2) @(negedge clk);
    check("reenable_no_tick_before_div", pdm_out_1, 0, 0);
    @(negedge clk);
    check("reenable_first_tick_pdm1", pdm_out_1, 1, 0);
    check("reenable_first_tick_pdm2", pdm_out_2, 1, 0);

    // Three back-to-back captures always include a non-tick overwrite.
    sample_in_1 = 12'hFFF; sample_in_2 = 12'hFFF; sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    sample_ready = 1'b0;
    check("overrun_burst", overrun, 1, 0);

    w = 0;
    while (pdm_out_1 !== 1'b1 && w < 32) begin
      @(negedge clk);
      w++;
    end
    check("pdm1_high_before_async_reset", pdm_out_1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pdm1", pdm_out_1, 0, 0);
    check("async_reset_pdm2", pdm_out_2, 0, 0);
    check("async_reset_overrun", overrun, 0, 0);
    check("async_reset_ramp_done", ramp_done, 0, 0);

    // Capture with the modulator stopped: no ticks, so any second capture overruns.
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    pulse_sample(12'h123, 12'h456);
    check("first_capture_no_overrun", overrun, 0, 0);
    pulse_sample(12'h234, 12'h567);
    check("second_capture_overrun", overrun, 1, 0);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0, 0);
    pulse_sample(12'h345, 12'h678);
    check("overrun_set_again", overrun, 1, 0);
    overrun_clr = 1'b1;
    pulse_sample(12'h456, 12'h789);
    overrun_clr = 1'b0;
    check("overrun_clr_priority", overrun, 0, 0);

    // Pending is still valid; land a capture exactly on the 4th edge after enable.
    en = 1'b1;
    repeat (3) @(negedge clk);
    pulse_sample(12'h567, 12'h89A);
    check("capture_on_tick_no_overrun", overrun, 0, 0);
    pulse_sample(12'h678, 12'h9AB);
    check("capture_after_tick_overrun", overrun, 1, 0);
    check("div1_never_overruns", d1_overrun, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sid_sd_dac.md
Name: sid_sd_dac

Overview:
- On-chip second-order delta-sigma audio DAC that consumes the two 12-bit sample streams produced by the SID/PSG sound core, using the same sample_ready strobe the external SPI DAC path uses.
- Drives two 1-bit PDM pins that are RC-filtered off chip.
- Gives a DAC-less audio option alongside the SPI DAC path.
- Adds channel routing, shift attenuation and a soft mute ramp so there are no clicks on reset or mute.

Parameters:
- DIV, 4: clocks per modulator tick (≥1); tick when div_ctr == DIV-1.
- IW, 16: integrator width in bits (signed).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_in_1  in  12  channel 1 sample, unsigned offset binary, 0x800 = midscale.
- sample_in_2  in  12  channel 2 sample, same format.
- sample_ready  in  1  1-clk strobe; both samples valid this cycle.
- en  in  1  modulator enable.
- mix_mode  in  2  routing: 0 = straight, 1 = mono average, 2 = swap, 3 = ch1 to both outputs.
- atten  in  3  arithmetic right shift applied after mixing.
- mute  in  1  1 = ramp to silence.
- overrun_clr  in  1  clears overrun.
- pdm_out_1  out  1  PDM bitstream, channel 1.
- pdm_out_2  out  1  PDM bitstream, channel 2.
- overrun  out  1  sticky: a sample was overwritten before it was consumed.
- ramp_done  out  1  1 when the ramp sits at its target (0 when muted, 256 when unmuted).

Behaviour:
- Reset (async, rst_n = 0):
  - div_ctr = 0, pending_valid = 0, pending and active regs = 0x800.
  - ramp = 0, integrators = 0.
  - pdm_out_1/2 = 0, overrun = 0, ramp_done = 0.
- Capture:
  - On sample_ready, latch both inputs into pending and set pending_valid.
  - If pending_valid is already 1 and no tick occurs in the same cycle: overwrite pending and set overrun.
- Tick:
  - en = 1: div_ctr counts 0..DIV-1 and wraps; tick = (div_ctr == DIV-1).
  - en = 0: div_ctr = 0, integrators = 0, pdm outputs = 0, ramp holds; capture still operates.
- Transfer on tick:
  - If pending_valid: active ← pending, pending_valid ← 0.
  - Tick and sample_ready in the same cycle: tick consumes the old pending, the new sample becomes pending, overrun is not set.
  - No pending on tick: active holds its last value (zero-order hold).
- Datapath, per tick, combinational from active:
  - Signed conversion: x_i = active_i - 2048, 12-bit signed.
  - Mode 1: m = (x1 + x2) >>> 1, computed in 13 bits, truncating; m drives both channels.
  - Other modes route per the mix_mode table.
  - Attenuate: a = m >>> atten.
  - Scale: s = (a * ramp) >>> 8, signed 12 × unsigned 9, result truncated to 12 bits.
  - Clamp s to [-1536, +1536].
- Ramp (9-bit, range 0..256), updated on tick:
  - mute = 0 and ramp < 256: ramp + 1.
  - mute = 1 and ramp > 0: ramp - 1.
  - ramp_done = (mute ? ramp == 0 : ramp == 256), registered.
- Modulator (per channel, on tick):
  - fb = y_prev ? +2048 : -2048.
  - i1 ← sat(i1 + s - fb).
  - i2 ← sat(i2 + i1_new - fb).
  - y = (i2_new ≥ 0); pdm_out ← y, registered.
  - sat clamps to ±(2^(IW-1) - 1).
  - Output changes only on tick, so latency from a captured sample to its first effect on pdm_out is ≤ 2 ticks.
- Long-run ones density = 0.5 + s/4096; the clamp bounds it to 12.5%..87.5%.
- overrun_clr takes priority over a same-cycle set: overrun reads 0 next cycle.
- DIV = 1: tick every clock.

Test Plan:
- Reset, then unmute, constant 0x800 on both channels, DIV = 4 → ramp_done rises 256 ticks (1024 clks) after reset; pdm_out_1/2 ones density over 1024 ticks = 50% ±1%.
- Constant 0xFFF, atten = 0, ramp full → clamp to +1536; density 87.5% ±1%. Same with atten = 2 (s = 511) → 62.5% ±1%.
- sample_ready twice within one tick period with no tick between → overrun = 1. Then overrun_clr pulse → overrun = 0. sample_ready coincident with tick while pending_valid → overrun stays 0.
- mix_mode = 1, s1 = 0xC00, s2 = 0x400 → both outputs 50% density. mix_mode = 2 → channels swapped, density compared against the mode-0 run.
- Assert mute at full ramp → ramp_done falls, then rises 256 ticks later; density converges to 50%; no integrator exceeds the saturation limit.
- Deassert rst_n mid-stream, asynchronously between clock edges → all outputs 0 immediately. en = 0 for 10 clks → pdm outputs 0 and integrators 0; on re-enable, first tick occurs DIV clks later.
